id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage of the RV32I core. Sits directly upstream of the 32-bit ALU.
- Decodes an RV32I integer instruction into the 4-bit ALU control code and two 32-bit ALU operands, then registers them.
- Valid/ready handshake on both sides, with a one-entry skid buffer so upstream never sees a combinational ready path.
- Flush input squashes in-flight entries on branch redirect.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode-side instruction valid
- in_ready  out  1  stage can accept; registered, equals !skid_full
- in_instr  in  32  instruction word
- in_pc  in  32  instruction address
- in_rs1_data  in  32  register-file read data for rs1
- in_rs2_data  in  32  register-file read data for rs2
- flush  in  1  squash all held entries
- out_valid  out  1  execute-side entry valid
- out_ready  in  1  execute stage accepts
- out_alu_ctrl  out  4  ALU control code
- out_sr1  out  32  ALU operand 1
- out_sr2  out  32  ALU operand 2
- out_rd  out  5  destination register
- out_rd_we  out  1  write enable; forced 0 when rd==0
- out_pc  out  32  pc of the entry
- out_illegal  out  1  entry carries an unsupported opcode/funct

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous, active-low.
- Values at reset: out_valid=0, in_ready=1, skid empty, all data outputs 0.
- ALU ctrl encoding is {funct3, alt}:
  - ADD 0000, SUB 0001, SLL 0010, SLT 0100, SLTU 0110, XOR 1000
  - SRL 1010, SRA 1011, OR 1100, AND 1110
  - PASS_SR1 1101, PASS_SR2 1111
- Decode, by opcode:
  - OP (0110011): sr1=rs1, sr2=rs2, ctrl={funct3, funct7[5]}. funct7[5] is legal only for funct3 000/101; any other funct7 is illegal.
  - OP-IMM (0010011): sr2=sign-extended imm[11:0], ctrl={funct3, 0}. Exceptions: funct3=101 uses alt=instr[30]; SLLI/SRLI/SRAI use shamt=instr[24:20] with a funct7 check.
  - LUI: sr1=0, sr2={imm[31:12], 12'b0}, ctrl=1111.
  - AUIPC: sr1=pc, sr2=U-imm, ctrl=ADD.
  - JAL/JALR: sr1=pc, sr2=4, ctrl=ADD (link value).
  - Anything else: illegal=1, rd_we=0, ctrl=0000.
- Output stage (main register) load rules:
  - Main register loads when it is empty or out_ready=1.
  - It loads from the skid buffer if the skid is full, otherwise from the input.
- Skid buffer:
  - Input is captured into the skid when in_valid && in_ready while the main register is full and out_ready=0.
  - in_ready deasserts the cycle after the skid fills. It reasserts the cycle after the skid drains into the main register.
- Ordering: strict FIFO order; no entry is dropped or duplicated.
- Latency: 1 cycle from input acceptance to out_valid with an empty pipe.
- Throughput: 1 instruction per cycle when out_ready is held high.
- Flush:
  - flush=1 at a clock edge clears out_valid and the skid.
  - An input handshake in the same cycle is discarded.
  - in_ready=1 next cycle. Flush has priority over all loads.
- Stability: data outputs are stable while out_valid && !out_ready.
- Simultaneous events: a full skid with out_ready=1 and in_valid=1 means skid→main and input→skid in the same cycle, only if in_ready was 1; otherwise skid→main only.
- Reset mid-operation discards all entries immediately (asynchronous).

Optional Feature:
- Macro: ID_EX_FWD_EN.
- With the macro defined, extra input ports are added: fwd_valid (1), fwd_rd (5), fwd_data (32).
  - When fwd_valid && fwd_rd!=0 && fwd_rd matches rs1/rs2 of the incoming instruction, fwd_data replaces in_rs1_data/in_rs2_data before operand selection.
  - Forwarding is applied at input capture only.
- Without the macro, the ports are absent and register-file data is used unmodified.

Test Plan:
- Reset then ADD: in_instr=0x002081B3 (add x3,x1,x2), rs1=5, rs2=7 → next cycle out_valid=1, ctrl=0000, sr1=5, sr2=7, rd=3, rd_we=1.
- SRAI: srai x5,x6,3 (0x40335293) → ctrl=1011, sr2=3. LUI 0x12345 into x1 → ctrl=1111, sr1=0, sr2=0x12345000.
- Backpressure: 3 back-to-back inputs with out_ready=0 → the first sits in main, the second in skid, in_ready=0 the following cycle. Release out_ready → outputs appear in order 1,2,3, with no loss.
- Flush with main+skid full and in_valid=1 → next cycle out_valid=0, in_ready=1; none of the three entries emerge.
- Illegal and x0: opcode 0x7F → out_illegal=1, rd_we=0. addi x0,x0,1 → rd_we=0.
- ID_EX_FWD_EN: fwd_valid=1, fwd_rd=1, fwd_data=0xDEADBEEF, add x3,x1,x2 → sr1=0xDEADBEEF. With fwd_rd=0 → sr1=in_rs1_data.

Source files
------------

// File: rtl/id_ex_stage.sv
// RV32I decode-to-execute stage: decodes ALU control/operands into a registered output with a one-entry skid buffer.
// Optional macro ID_EX_FWD_EN adds a forwarding port applied to register-file data at input capture.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic            flush,
`ifdef ID_EX_FWD_EN
  input  logic            fwd_valid,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_ctrl,
  output logic [XLEN-1:0] out_sr1,
  output logic [XLEN-1:0] out_sr2,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  typedef struct packed {
    logic [3:0]      ctrl;
    logic [XLEN-1:0] sr1;
    logic [XLEN-1:0] sr2;
    logic [4:0]      rd;
    logic            rd_we;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } entry_t;

  entry_t          dec;
  entry_t          main_q;
  entry_t          skid_q;
  logic            main_valid;
  logic            skid_full;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            ill;
  logic            accept;
  logic            main_load;

  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  // Operand source selection, with optional forwarding override
  always_comb begin
    rs1_val = in_rs1_data;
    rs2_val = in_rs2_data;
`ifdef ID_EX_FWD_EN
    if (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == in_instr[19:15])) begin
      rs1_val = fwd_data;
    end else begin
      rs1_val = in_rs1_data;
    end
    if (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == in_instr[24:20])) begin
      rs2_val = fwd_data;
    end else begin
      rs2_val = in_rs2_data;
    end
`endif
  end

  // Instruction decode into an ALU entry; illegal encodings collapse to ctrl 0 with zero operands
  always_comb begin
    dec    = '0;
    ill    = 1'b0;
    dec.pc = in_pc;
    dec.rd = in_instr[11:7];
    case (in_instr[6:0])
      7'b0110011: begin
        dec.sr1  = rs1_val;
        dec.sr2  = rs2_val;
        dec.ctrl = {funct3, funct7[5]};
        if ((funct7 == 7'b0000000) ||
            ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
          ill = 1'b0;
        end else begin
          ill = 1'b1;
        end
      end
      7'b0010011: begin
        dec.sr1 = rs1_val;
        if (funct3 == 3'b001) begin
          dec.sr2  = {27'd0, in_instr[24:20]};
          dec.ctrl = 4'b0010;
          ill      = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          dec.sr2  = {27'd0, in_instr[24:20]};
          dec.ctrl = {funct3, in_instr[30]};
          ill      = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
        end else begin
          dec.sr2  = {{20{in_instr[31]}}, in_instr[31:20]};
          dec.ctrl = {funct3, 1'b0};
        end
      end
      7'b0110111: begin
        dec.sr2  = {in_instr[31:12], 12'd0};
        dec.ctrl = 4'b1111;
      end
      7'b0010111: begin
        dec.sr1  = in_pc;
        dec.sr2  = {in_instr[31:12], 12'd0};
        dec.ctrl = 4'b0000;
      end
      7'b1101111, 7'b1100111: begin
        dec.sr1  = in_pc;
        dec.sr2  = 32'd4;
        dec.ctrl = 4'b0000;
      end
      default: begin
        ill = 1'b1;
      end
    endcase
    if (ill) begin
      dec.ctrl = 4'b0000;
      dec.sr1  = '0;
      dec.sr2  = '0;
    end else begin
      dec.ctrl = dec.ctrl;
    end
    dec.illegal = ill;
    dec.rd_we   = !ill && (dec.rd != 5'd0);
  end

  assign in_ready  = ~skid_full;
  assign accept    = in_valid && in_ready;
  assign main_load = !main_valid || out_ready;

  // Main output register and skid buffer; the skid always drains before new input reaches main
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_full  <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_full  <= 1'b0;
    end else if (main_load) begin
      if (skid_full) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_full  <= 1'b0;
      end else if (accept) begin
        main_q     <= dec;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q    <= dec;
      skid_full <= 1'b1;
    end else begin
      skid_full <= skid_full;
    end
  end

  assign out_valid    = main_valid;
  assign out_alu_ctrl = main_q.ctrl;
  assign out_sr1      = main_q.sr1;
  assign out_sr2      = main_q.sr2;
  assign out_rd       = main_q.rd;
  assign out_rd_we    = main_q.rd_we;
  assign out_pc       = main_q.pc;
  assign out_illegal  = main_q.illegal;

endmodule
